// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Accepts retiring instructions from
// MEM, waits for load data when needed, formats load bytes/halfwords and
// drives a registered single-cycle register-file write (LD/DR/D_IN).
// Optional feature macro: WB_RETIRE_COUNTER_EN adds a 64-bit RETIRE_COUNT
// output that counts every COMMIT cycle.
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [REG_AW-1:0] IN_RD,
    input  logic [1:0]        IN_WB_SEL,
    input  logic [XLEN-1:0]   IN_ALU,
    input  logic [XLEN-1:0]   IN_PC4,
    input  logic [2:0]        IN_FUNCT3,
    input  logic [1:0]        IN_ADDR_LO,
    input  logic              MEM_RVALID,
    input  logic [XLEN-1:0]   MEM_RDATA,
    output logic              LD,
    output logic [REG_AW-1:0] DR,
    output logic [XLEN-1:0]   D_IN
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]       RETIRE_COUNT
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [1:0]        r_state;
    logic [REG_AW-1:0] r_rd;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_ld;
    logic [REG_AW-1:0] r_dr;
    logic [XLEN-1:0]   r_din;

    logic              w_accept;
    logic              w_is_load;
    logic [XLEN-1:0]   w_nonload_data;
    logic [XLEN-1:0]   w_byte_sh;
    logic [XLEN-1:0]   w_half_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    assign IN_READY  = (r_state != S_WAIT);
    assign w_accept  = IN_VALID && IN_READY;
    assign w_is_load = (IN_WB_SEL == SEL_LOAD);

    // Non-load result source: PC+4 for jumps, ALU otherwise (11 also maps to ALU).
    always_comb begin
        w_nonload_data = IN_ALU;
        if (IN_WB_SEL == SEL_PC4)
            w_nonload_data = IN_PC4;
    end

    // Align the captured load lane out of the raw word and extend per funct3.
    always_comb begin
        w_byte_sh   = MEM_RDATA >> {r_addr_lo, 3'b000};
        w_half_sh   = MEM_RDATA >> {r_addr_lo[1], 4'b0000};
        w_byte      = w_byte_sh[7:0];
        w_half      = w_half_sh[15:0];
        w_load_data = MEM_RDATA;
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = MEM_RDATA;
        endcase
    end

    // State machine plus registered write port; x0 retires but never asserts LD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_ld      <= 1'b0;
            r_dr      <= '0;
            r_din     <= '0;
        end else begin
            r_ld <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (MEM_RVALID) begin
                        r_state <= S_COMMIT;
                        r_ld    <= (r_rd != '0);
                        r_dr    <= r_rd;
                        r_din   <= w_load_data;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_is_load) begin
                            r_state   <= S_WAIT;
                            r_rd      <= IN_RD;
                            r_funct3  <= IN_FUNCT3;
                            r_addr_lo <= IN_ADDR_LO;
                        end else begin
                            r_state <= S_COMMIT;
                            r_ld    <= (IN_RD != '0);
                            r_dr    <= IN_RD;
                            r_din   <= w_nonload_data;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign LD   = r_ld;
    assign DR   = r_dr;
    assign D_IN = r_din;

`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] r_retire_cnt;

    // Count every COMMIT cycle, x0 retirements included; wraps naturally.
    always_ff @(posedge CLK) begin
        if (RST)
            r_retire_cnt <= '0;
        else if (r_state == S_COMMIT)
            r_retire_cnt <= r_retire_cnt + 64'd1;
    end

    assign RETIRE_COUNT = r_retire_cnt;
`endif

endmodule
